axi_mm_ll_tx_credit: RTL and testbench



---
 rtl/axi_mm_ll_tx_credit.sv | 108 ++++++++++
 tb/tb_axi_mm_ll_tx_credit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mm_ll_tx_credit.sv
`default_nettype none
// ============================================================================
// Module   : axi_mm_ll_tx_credit
// Purpose  : Credit-gated transmit FIFO for one logic-link channel; words are
//            issued to the adapter only while far-side credit is available.
// Revision : 1.0
// ============================================================================
module axi_mm_ll_tx_credit #(
    parameter int WIDTH      = 149,
    parameter int DEPTH      = 8,
    parameter int CREDIT_MAX = 8
) (
    input  logic                            clk_wr,
    input  logic                            rst_wr_n,
    input  logic                            user_vld,
    input  logic [WIDTH-1:0]                txfifo_data,
    output logic                            user_ready,
    input  logic                            link_en,
    output logic                            tx_vld,
    output logic [WIDTH-1:0]                tx_data,
    input  logic                            credit_ret,
    output logic [$clog2(DEPTH):0]          fifo_cnt,
    output logic [$clog2(CREDIT_MAX):0]     credit_cnt,
    output logic                            credit_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = $clog2(CREDIT_MAX) + 1;

    localparam logic [CW-1:0] FIFO_FULL  = CW'(DEPTH);
    localparam logic [KW-1:0] CREDIT_TOP = KW'(CREDIT_MAX);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [0:0]       r_state;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic [KW-1:0]    r_credit;
    logic             r_credit_err;
    logic             r_tx_vld;
    logic [WIDTH-1:0] r_tx_data;

    logic w_push;
    logic w_pop;
    logic w_credit_ok;

    assign user_ready  = (r_cnt != FIFO_FULL);
    assign w_push      = user_vld & user_ready;
    // A credit arriving on the same edge can fund that edge's pop (net zero).
    assign w_credit_ok = (r_credit != '0) | credit_ret;
    assign w_pop       = (r_state == ST_RUN) & (r_cnt != '0) & w_credit_ok;

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_credit     <= CREDIT_TOP;
            r_credit_err <= 1'b0;
            r_tx_vld     <= 1'b0;
            r_tx_data    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (link_en)  r_state <= ST_RUN;
                ST_RUN:  if (!link_en) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            r_tx_vld <= w_pop;
            if (w_pop) r_tx_data <= mem[r_rd_ptr];

            if (w_pop && !credit_ret) begin
                r_credit <= r_credit - 1'b1;
            end else if (!w_pop && credit_ret) begin
                if (r_credit == CREDIT_TOP) r_credit_err <= 1'b1;
                else                        r_credit     <= r_credit + 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_wr) begin
        if (w_push) mem[r_wr_ptr] <= txfifo_data;
    end

    assign tx_vld     = r_tx_vld;
    assign tx_data    = r_tx_data;
    assign fifo_cnt   = r_cnt;
    assign credit_cnt = r_credit;
    assign credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_mm_ll_tx_credit.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mm_ll_tx_credit
// Purpose  : Directed bench with a queue-based reference model for the
//            credit-gated transmit FIFO.
// Revision : 1.0
// ============================================================================
module tb_axi_mm_ll_tx_credit;

    localparam int WIDTH      = 149;
    localparam int DEPTH      = 8;
    localparam int CREDIT_MAX = 8;

    logic                        clk_wr = 1'b0;
    logic                        rst_wr_n;
    logic                        user_vld;
    logic [WIDTH-1:0]            txfifo_data;
    logic                        user_ready;
    logic                        link_en;
    logic                        tx_vld;
    logic [WIDTH-1:0]            tx_data;
    logic                        credit_ret;
    logic [$clog2(DEPTH):0]      fifo_cnt;
    logic [$clog2(CREDIT_MAX):0] credit_cnt;
    logic                        credit_err;

    int total = 0;
    int bad   = 0;

    axi_mm_ll_tx_credit #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .CREDIT_MAX (CREDIT_MAX)
    ) dut (
        .clk_wr      (clk_wr),
        .rst_wr_n    (rst_wr_n),
        .user_vld    (user_vld),
        .txfifo_data (txfifo_data),
        .user_ready  (user_ready),
        .link_en     (link_en),
        .tx_vld      (tx_vld),
        .tx_data     (tx_data),
        .credit_ret  (credit_ret),
        .fifo_cnt    (fifo_cnt),
        .credit_cnt  (credit_cnt),
        .credit_err  (credit_err)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a word queue plus an integer credit balance.
    logic [WIDTH-1:0] mq[$];
    int               m_credit;
    bit               m_err, m_run, m_vld, model_ok = 0;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] emitted[$];

    always @(posedge clk_wr) begin
        bit can_pop;
        if (!rst_wr_n) begin
            mq.delete();
            m_credit = CREDIT_MAX;
            m_err    = 0;
            m_run    = 0;
            m_vld    = 0;
            m_data   = '0;
            model_ok = 1;
        end else begin
            can_pop = m_run && (mq.size() > 0) && (m_credit > 0 || credit_ret);
            m_vld = can_pop;
            if (can_pop) m_data = mq.pop_front();
            if (user_vld && mq.size() + (can_pop ? 1 : 0) != DEPTH)
                mq.push_back(txfifo_data);
            m_credit = m_credit - (can_pop ? 1 : 0) + (credit_ret ? 1 : 0);
            if (m_credit > CREDIT_MAX) begin
                m_credit = CREDIT_MAX;
                m_err    = 1;
            end
            m_run = link_en;
        end
    end

    always @(negedge clk_wr) begin
        if (model_ok) begin
            check("user_ready", user_ready, (mq.size() != DEPTH));
            check("tx_vld",     tx_vld,     m_vld);
            check("tx_data",    tx_data,    m_data);
            check("fifo_cnt",   fifo_cnt,   mq.size());
            check("credit_cnt", credit_cnt, m_credit);
            check("credit_err", credit_err, m_err);
            if (tx_vld) emitted.push_back(tx_data);
        end
    end

    task automatic tick;
        @(negedge clk_wr);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_wr_n = 0; user_vld = 0; txfifo_data = '0; link_en = 0; credit_ret = 0;
        tick;
        check("rst_fifo_cnt",   fifo_cnt,   0);
        check("rst_credit_cnt", credit_cnt, 8);
        check("rst_user_ready", user_ready, 1);
        check("rst_tx_vld",     tx_vld,     0);
        check("rst_tx_data",    tx_data,    0);
        check("rst_credit_err", credit_err, 0);
        tick;
        rst_wr_n = 1;

        // Credit limit: 10 words, only 8 credits.
        emitted.delete();
        link_en = 1;
        for (int i = 1; i <= 10; i++) begin
            user_vld = 1; txfifo_data = WIDTH'(i);
            tick;
            check("t1_user_ready", user_ready, 1);
        end
        user_vld = 0;
        repeat (6) tick;
        check("t1_emit_count", emitted.size(), 8);
        for (int i = 0; i < emitted.size(); i++) check("t1_emit_data", emitted[i], i + 1);
        check("t1_credit_cnt", credit_cnt, 0);
        check("t1_fifo_cnt",   fifo_cnt,   2);

        // Credit return releases the two held words.
        emitted.delete();
        credit_ret = 1;
        repeat (2) tick;
        credit_ret = 0;
        repeat (4) tick;
        check("t2_emit_count", emitted.size(), 2);
        if (emitted.size() == 2) begin
            check("t2_emit0", emitted[0], 'h9);
            check("t2_emit1", emitted[1], 'hA);
        end
        check("t2_fifo_cnt",   fifo_cnt,   0);
        check("t2_credit_cnt", credit_cnt, 0);

        // Fill FIFO with link down, then release.
        link_en = 0; credit_ret = 1;
        repeat (8) tick;
        credit_ret = 0;
        tick;
        check("t3_credit_refill", credit_cnt, 8);
        emitted.delete();
        for (int i = 0; i < 8; i++) begin
            user_vld = 1; txfifo_data = WIDTH'('h10 + i);
            tick;
        end
        check("t3_full_ready", user_ready, 0);
        check("t3_full_cnt",   fifo_cnt,   8);
        txfifo_data = WIDTH'('h18);
        repeat (3) begin
            tick;
            check("t3_held_cnt", fifo_cnt, 8);
        end
        user_vld = 0;
        link_en = 1;
        tick;
        check("t3_lat1_vld",   tx_vld,     0);
        check("t3_lat1_ready", user_ready, 0);
        tick;
        check("t3_lat2_vld",   tx_vld,     1);
        check("t3_lat2_data",  tx_data,    'h10);
        check("t3_lat2_ready", user_ready, 1);
        repeat (10) tick;
        check("t3_emit_count", emitted.size(), 8);
        if (emitted.size() == 8) check("t3_emit_last", emitted[7], 'h17);
        check("t3_fifo_cnt",   fifo_cnt,   0);
        check("t3_credit_cnt", credit_cnt, 0);

        // Steady push/pop with credit return each cycle.
        credit_ret = 1;
        repeat (4) tick;
        credit_ret = 0;
        tick;
        check("t4_credit_pre", credit_cnt, 4);
        emitted.delete();
        for (int i = 0; i < 20; i++) begin
            user_vld = 1; credit_ret = 1; txfifo_data = WIDTH'('h100 + i);
            tick;
            check("t4_fifo_const",   fifo_cnt,   1);
            check("t4_credit_const", credit_cnt, 5);
        end
        user_vld = 0; credit_ret = 0;
        repeat (3) tick;
        check("t4_emit_count", emitted.size(), 20);
        for (int i = 0; i < emitted.size(); i++) check("t4_emit_order", emitted[i], 'h100 + i);
        check("t4_credit_post", credit_cnt, 4);
        check("t4_fifo_post",   fifo_cnt,   0);

        // Over-return at the ceiling.
        credit_ret = 1;
        repeat (4) tick;
        check("t4_ceiling",     credit_cnt, 8);
        check("t4_err_before",  credit_err, 0);
        tick;
        credit_ret = 0;
        check("t4_over_credit", credit_cnt, 8);
        check("t4_over_err",    credit_err, 1);

        // Build fifo_cnt = 5, credit_cnt = 3, then reset.
        for (int i = 0; i < 5; i++) begin
            user_vld = 1; txfifo_data = WIDTH'('h200 + i);
            tick;
        end
        user_vld = 0;
        repeat (4) tick;
        link_en = 0;
        repeat (2) tick;
        for (int i = 0; i < 5; i++) begin
            user_vld = 1; txfifo_data = WIDTH'('h300 + i);
            tick;
        end
        user_vld = 0;
        check("t5_pre_fifo",   fifo_cnt,   5);
        check("t5_pre_credit", credit_cnt, 3);
        rst_wr_n = 0;
        tick;
        check("t5_rst_fifo",   fifo_cnt,   0);
        check("t5_rst_credit", credit_cnt, 8);
        check("t5_rst_vld",    tx_vld,     0);
        check("t5_rst_err",    credit_err, 0);
        check("t5_rst_ready",  user_ready, 1);
        rst_wr_n = 1; link_en = 1;
        emitted.delete();
        repeat (8) tick;
        check("t5_no_stale", emitted.size(), 0);
        user_vld = 1; txfifo_data = WIDTH'('h400);
        tick;
        user_vld = 0;
        repeat (3) tick;
        check("t5_post_count", emitted.size(), 1);
        if (emitted.size() == 1) check("t5_post_data", emitted[0], 'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
